uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 45 ++++
 rtl/uart_tx_param.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and frame-length math.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Total BitClk cycles from accept edge to the edge that raises TxDone.
    function automatic int frame_len(input int clks_per_bit, input int data_bits,
                                     input int parity, input int stop_bits);
        return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates, otherwise wrap at the last cycle of the bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: load/busy handshake, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 BitClk,
    input  logic                 Reset,
    input  logic                 LoadTx,
    input  logic [DATA_BITS-1:0] DataIn,
    output logic                 TxBusy,
    output logic                 TxDone,
    output logic                 SerialOut
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS=%0d outside 5..9", DATA_BITS);
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_param: PARITY=%0d must be 0, 1 or 2", PARITY);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end
    if (CLKS_PER_BIT < 2 || (1 << CNT_W) < CLKS_PER_BIT) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT=%0d illegal for CNT_W=%0d", CLKS_PER_BIT, CNT_W);
    end

    // Bit counter is shared between data bits and stop bits.
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] LAST_STOP = BC_W'(STOP_BITS - 1);
    localparam logic            ODD_INV   = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end_s;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (BitClk),
        .rst     (Reset),
        .clr     (state_q == S_IDLE),
        .en      (state_q != S_IDLE),
        .bit_end (bit_end_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (LoadTx) begin
                    state_d   = S_START;
                    shift_d   = DataIn;
                    par_d     = (^DataIn) ^ ODD_INV;
                    bit_cnt_d = '0;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        serial_d  = shift_q[1];
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                    serial_d  = 1'b1;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = S_IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                shift_d   = '0;
                bit_cnt_d = '0;
                serial_d  = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the idle line immediately.
    always_ff @(posedge BitClk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SerialOut = serial_q;
    assign TxBusy    = busy_q;
    assign TxDone    = done_q;

endmodule
